// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state encoding and I2C field widths for the transaction arbiter
//
// Purpose: common definitions imported by i2c_txn_arbiter and its helpers.
//   ADDR_W / REG_W / DATA_W : widths of the slave address, register address and data fields
//   arb_state_t             : arbiter FSM states
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5,
    FAIL      = 3'd6
  } arb_state_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// rtl/i2c_txn_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: choose the first set request bit searching upward from ptr+1, wrapping.
// Ports:
//   req  in   NUM_REQ  request vector
//   ptr  in   3        index of the previous winner (must be < NUM_REQ)
//   gnt  out  NUM_REQ  one-hot winner (all zero when no request)
//   idx  out  3        index of the winner
//   any  out  1        at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         idx,
  output logic               any
);

  logic [7:0] req8;

  assign req8 = 8'(req);

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  // Offsets 1..NUM_REQ visit ptr+1 first and ptr itself last, so the
  // previous winner only wins again when nobody else is asking.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req8[wrap_idx(ptr, k)]) begin
        any = 1'b1;
        idx = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = any && (idx == 3'(i));
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one I2C master between requesters
//
// Purpose: pick a requester, latch its transaction onto the master, pulse en once,
//   follow busy to completion and report done (with read data) or err on timeout.
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   req, req_rw              per-requester level request and direction (1 = read)
//   req_addr/addr2/dataW     packed per-requester fields, slice i at [W*i +: W]
//   gnt, done, err           one-hot single-cycle pulses back to the requesters
//   rd_data, owner           last read result and current/last owner index
//   mst_en/rw/addr/addr2/dataW  command to the master (en is a single-cycle pulse)
//   mst_dataR, mst_busy      status from the master
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 1000,
  parameter int TXN_TIMEOUT   = 200000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [REG_W*NUM_REQ-1:0]  req_addr2,
  input  logic [DATA_W*NUM_REQ-1:0] req_dataW,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rd_data,
  output logic [2:0]                owner,
  output logic                      mst_en,
  output logic                      mst_rw,
  output logic [ADDR_W-1:0]         mst_addr,
  output logic [REG_W-1:0]          mst_addr2,
  output logic [DATA_W-1:0]         mst_dataW,
  input  logic [DATA_W-1:0]         mst_dataR,
  input  logic                      mst_busy
);

  localparam int TW = $clog2(TXN_TIMEOUT + 1);

  arb_state_t         state, state_d;
  logic [TW-1:0]      timer;
  logic [2:0]         ptr;

  logic [NUM_REQ-1:0] pick_oh;
  logic [2:0]         pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] gnt_d, done_d, err_d;
  logic               en_d;
  logic               latch;

  // Fields unpacked into fixed 8-entry tables so the 3-bit winner index
  // selects them directly for any NUM_REQ; unused entries read as zero.
  logic [7:0]        rw8;
  logic [ADDR_W-1:0] addr_a  [8];
  logic [REG_W-1:0]  addr2_a [8];
  logic [DATA_W-1:0] dataw_a [8];

  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < NUM_REQ) begin : g_used
      assign rw8[g]     = req_rw[g];
      assign addr_a[g]  = req_addr[ADDR_W*g +: ADDR_W];
      assign addr2_a[g] = req_addr2[REG_W*g +: REG_W];
      assign dataw_a[g] = req_dataW[DATA_W*g +: DATA_W];
    end else begin : g_unused
      assign rw8[g]     = 1'b0;
      assign addr_a[g]  = '0;
      assign addr2_a[g] = '0;
      assign dataw_a[g] = '0;
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_oh[i] = (owner == 3'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    en_d    = 1'b0;
    latch   = 1'b0;
    case (state)
      SYNC: begin
        // The master is never reset, so wait for it to be quiet first.
        if (!mst_busy) state_d = IDLE;
      end
      IDLE: begin
        if (!mst_busy && pick_any) begin
          gnt_d   = pick_oh;
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        en_d    = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mst_busy)                            state_d = WAIT_DONE;
        else if (timer >= TW'(START_TIMEOUT))    state_d = FAIL;
      end
      WAIT_DONE: begin
        if (!mst_busy)                           state_d = FINISH;
        else if (timer >= TW'(TXN_TIMEOUT))      state_d = FAIL;
      end
      FINISH: begin
        done_d  = own_oh;
        state_d = IDLE;
      end
      FAIL: begin
        // Back through SYNC so a hung transfer drains before the next grant.
        err_d   = own_oh;
        state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
  end

  // All requester-facing pulses are registered, which puts gnt in the
  // ISSUE cycle and mst_en exactly one cycle after it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= '0;
      ptr       <= 3'(NUM_REQ - 1);
      owner     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rd_data   <= '0;
      mst_en    <= 1'b0;
      mst_rw    <= 1'b0;
      mst_addr  <= '0;
      mst_addr2 <= '0;
      mst_dataW <= '0;
    end else begin
      gnt    <= gnt_d;
      done   <= done_d;
      err    <= err_d;
      mst_en <= en_d;

      if (state_d != state)   timer <= '0;
      else if (timer != '1)   timer <= timer + 1'b1;

      if (latch) begin
        owner     <= pick_idx;
        ptr       <= pick_idx;
        mst_rw    <= rw8[pick_idx];
        mst_addr  <= addr_a[pick_idx];
        mst_addr2 <= addr2_a[pick_idx];
        mst_dataW <= dataw_a[pick_idx];
      end

      if (state == FINISH && mst_rw) rd_data <= mst_dataR;
    end
  end

endmodule
